pixel_triplet_packer: RTL and testbench
=======================================

// Module: pixel_triplet_packer
// PURPOSE
//  Front-end stage feeding the main control unit: accepts one 5-bit pixel per cycle (valid/ready),
//  frames it into a 20x20 image and emits raster-order triplets matching pixel_in0/1/2 (3 px/cycle).
//  400 px -> 134 groups; last group holds 1 pixel, zero-padded. Flags the last group and frame end.
// PARAMETERS
//  IMG_DIM     20   image width/height in pixels
//  BIT_LENGTH  5    pixel width in bits
//  TOTAL_PIX   IMG_DIM*IMG_DIM   pixels per frame (derived; not overridable separately)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  in_valid    in   1      upstream pixel valid
//  in_ready    out  1      packer can accept a pixel
//  in_sof      in   1      qualifies in_pixel as pixel 0 of a frame (sampled with in_valid)
//  in_pixel    in   BIT_LENGTH  pixel value
//  out_valid   out  1      triplet valid
//  out_ready   in   1      downstream accepts triplet
//  pixel_out0  out  BIT_LENGTH  earliest pixel of triplet (raster order)
//  pixel_out1  out  BIT_LENGTH  second pixel (0 if padded)
//  pixel_out2  out  BIT_LENGTH  third pixel (0 if padded)
//  out_last    out  1      current triplet is last of frame (qualified by out_valid)
//  frame_done  out  1      1-cycle pulse: last triplet handshake completed
//  sof_err     out  1      1-cycle pulse: in_sof accepted mid-frame (frame restarted)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except in_ready=1; counters/slots cleared. Reset mid-frame
//    discards partial group and any held output triplet; no frame_done/sof_err emitted.
//  - Handshake: in transfer = in_valid&in_ready; out transfer = out_valid&out_ready. Once out_valid=1,
//    pixel_out*/out_last stay stable until transfer (no retraction).
//  - States: IDLE -> RUN on accepted pixel with in_sof; RUN -> DRAIN when pixel TOTAL_PIX-1 accepted;
//    DRAIN -> IDLE on out transfer with out_last=1 (frame_done pulses that cycle).
//  - IDLE: in_ready=1; pixels without in_sof are consumed and dropped.
//  - Assembly: 3 slots + fill count 0..2; pixel index counter 0..TOTAL_PIX-1 (9 bits).
//    Group closes on 3rd pixel or on pixel TOTAL_PIX-1 (unused slots forced to 0, out_last=1).
//  - Output register: closed group is loaded at the same edge if output is free
//    (out_valid=0 or out transfer this cycle) -> out_valid rises 1 cycle after the closing pixel.
//    Otherwise group held in slots (full), in_ready=0 until output frees; load at that edge.
//  - Throughput: 1 px/cycle sustained with out_ready=1; no bubbles between frames beyond DRAIN.
//  - in_ready=0 in DRAIN while last group is pending in slots; in_ready=1 in DRAIN once it is in the
//    output register, but incoming pixels are consumed only if in_sof=1 (next frame may start, state->RUN,
//    frame_done still pulses on last-triplet transfer); non-sof pixels in DRAIN are dropped.
//  - in_sof accepted in RUN: sof_err pulses, partial group and index discarded, pixel becomes index 0.
//    An already-loaded output triplet is still delivered (out_last=0).
//  - Simultaneous out transfer and group close: old triplet leaves, new loads, out_valid stays 1.
//  - Counter never wraps inside a frame; index resets to 0 only on in_sof acceptance or reset.
// STRUCTURE
//  - Shared package img_pkg: IMG_DIM, BIT_LENGTH, TOTAL_PIX, NUM_GROUPS (=134), pixel_t typedef,
//    packer_state_t enum {IDLE,RUN,DRAIN}; reused by main control unit.
//  - Single module, no sub-modules; assembly slots and output register inline.
// TESTING
//  - Frame 0..399 (px = i mod 32), in_valid=1, out_ready=1, sof on px0 -> 134 triplets, first (0,1,2)
//    out_valid 1 cycle after px2; last (15,0,0) out_last=1; frame_done 1 cycle after last px.
//  - Same frame, out_ready low 10 cycles at triplet 5 -> in_ready drops after 3 more px, no loss/dup,
//    outputs stable while stalled.
//  - Pixels 7,8 without sof in IDLE, then sof frame -> 7,8 dropped, first triplet from sof pixel.
//  - sof re-asserted at pixel 200 (index 200, partial group of 2) -> sof_err pulse, 134 clean triplets follow.
//  - Back-to-back frames, sof on cycle after px399 -> no gap; frame_done pulses once per frame.
//  - Reset asserted at pixel 100 with out_valid=1 -> next cycle out_valid=0, in_ready=1, state IDLE.

Source files
------------

// File: rtl/img_pkg.sv
// Image geometry and pixel types shared by the triplet packer and the main control unit.
package img_pkg;

  localparam int unsigned IMG_DIM    = 20;
  localparam int unsigned BIT_LENGTH = 5;
  localparam int unsigned TOTAL_PIX  = IMG_DIM * IMG_DIM;
  localparam int unsigned NUM_GROUPS = (TOTAL_PIX + 2) / 3;

  typedef logic [BIT_LENGTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } packer_state_t;

endpackage

// File: rtl/pixel_triplet_packer_if.sv
// Pixel stream in, raster-order triplet stream out; slave = packer side, master = driver side.
interface pixel_triplet_packer_if
  import img_pkg::*;
();

  logic   in_valid;
  logic   in_ready;
  logic   in_sof;
  pixel_t in_pixel;
  logic   out_valid;
  logic   out_ready;
  pixel_t pixel_out0;
  pixel_t pixel_out1;
  pixel_t pixel_out2;
  logic   out_last;
  logic   frame_done;
  logic   sof_err;

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, pixel_out0, pixel_out1, pixel_out2, out_last, frame_done, sof_err
  );

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, pixel_out0, pixel_out1, pixel_out2, out_last, frame_done, sof_err
  );

endinterface

// File: rtl/pixel_triplet_packer.sv
// Frames a 1 px/cycle stream into IMG_DIM x IMG_DIM images and emits raster-order pixel triplets,
// zero-padding the final short group of each frame.
module pixel_triplet_packer #(
  parameter int unsigned IMG_DIM    = img_pkg::IMG_DIM,
  parameter int unsigned BIT_LENGTH = img_pkg::BIT_LENGTH
) (
  input logic                  clk,
  input logic                  reset,
  pixel_triplet_packer_if.slave bus
);
  import img_pkg::*;

  localparam int unsigned        TOTAL    = IMG_DIM * IMG_DIM;
  localparam int unsigned        IDX_W    = $clog2(TOTAL);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(TOTAL - 1);

  packer_state_t         r_state;
  logic [BIT_LENGTH-1:0] r_slot [3];
  logic [1:0]            r_fill;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_full;
  logic                  r_pend_last;
  logic [BIT_LENGTH-1:0] r_out [3];
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_out_free;
  logic                  w_sof_acc;
  logic                  w_take;
  logic [1:0]            w_pos;
  logic [IDX_W-1:0]      w_pidx;
  logic                  w_is_last;
  logic                  w_close;
  logic [BIT_LENGTH-1:0] w_grp [3];

  assign w_in_xfer  = bus.in_valid & ~r_full;
  assign w_out_xfer = r_out_valid & bus.out_ready;
  assign w_out_free = ~r_out_valid | bus.out_ready;
  assign w_sof_acc  = w_in_xfer & bus.in_sof;
  // Only sof pixels or in-frame pixels enter assembly; everything else accepted is dropped.
  assign w_take     = w_sof_acc | (w_in_xfer & (r_state == RUN));
  assign w_pos      = w_sof_acc ? 2'd0 : r_fill;
  assign w_pidx     = w_sof_acc ? '0 : r_idx;
  assign w_is_last  = (w_pidx == LAST_IDX);
  assign w_close    = w_take & ((w_pos == 2'd2) | w_is_last);

  always_comb begin
    w_grp = '{default: '0};
    for (int k = 0; k < 3; k++) begin
      if (k < int'(w_pos)) begin
        w_grp[k] = r_slot[k];
      end else if (k == int'(w_pos)) begin
        w_grp[k] = bus.in_pixel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_slot      <= '{default: '0};
      r_fill      <= 2'd0;
      r_idx       <= '0;
      r_full      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out       <= '{default: '0};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      // Output register: a held group has priority; a freshly closed one bypasses the slots.
      if (r_full && w_out_free) begin
        r_out       <= r_slot;
        r_out_last  <= r_pend_last;
        r_out_valid <= 1'b1;
        r_full      <= 1'b0;
      end else if (w_close && w_out_free) begin
        r_out       <= w_grp;
        r_out_last  <= w_is_last;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_take) begin
        r_idx <= w_pidx + IDX_W'(1);
        if (w_close) begin
          r_fill <= 2'd0;
          if (!w_out_free) begin
            r_slot      <= w_grp;
            r_full      <= 1'b1;
            r_pend_last <= w_is_last;
          end
        end else begin
          r_slot[w_pos] <= bus.in_pixel;
          r_fill        <= w_pos + 2'd1;
        end
      end

      unique case (r_state)
        IDLE: begin
          if (w_sof_acc) r_state <= RUN;
        end
        RUN: begin
          if (w_take && w_is_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_sof_acc) begin
            r_state <= RUN;
          end else if (w_out_xfer && r_out_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = ~r_full;
  assign bus.out_valid  = r_out_valid;
  assign bus.pixel_out0 = r_out[0];
  assign bus.pixel_out1 = r_out[1];
  assign bus.pixel_out2 = r_out[2];
  assign bus.out_last   = r_out_last;
  assign bus.frame_done = w_out_xfer & r_out_last;
  assign bus.sof_err    = w_sof_acc & (r_state == RUN);

endmodule

// File: tb/tb_pixel_triplet_packer.sv
// Directed bench for pixel_triplet_packer: frames of px = i mod 32 with hand-derived triplets.
module tb_pixel_triplet_packer;
  import img_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_triplet_packer_if bus_if ();

  pixel_triplet_packer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Triplet records: {out_last, pixel_out0, pixel_out1, pixel_out2}
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int n_fd, n_se, fd_cyc, se_cyc, first_ov_cyc, acc_cnt, blk_at, n_unstable;
  logic [15:0] held;
  bit held_v;
  int stall_at  = -1;
  int stall_rem = 0;
  bit force_stall = 1'b0;

  task automatic reset_stats();
    got_q.delete();
    exp_q.delete();
    n_fd = 0; n_se = 0; fd_cyc = -1; se_cyc = -1; first_ov_cyc = -1;
    acc_cnt = 0; blk_at = -1; n_unstable = 0; held_v = 1'b0;
  endtask

  // One clock: choose out_ready, sample at negedge, return 1 time unit after posedge.
  task automatic step();
    logic [15:0] cur;
    if (force_stall) begin
      bus_if.out_ready = 1'b0;
    end else if (stall_rem > 0 && bus_if.out_valid && got_q.size() == stall_at) begin
      bus_if.out_ready = 1'b0;
      stall_rem--;
    end else begin
      bus_if.out_ready = 1'b1;
    end
    @(negedge clk);
    if (!reset) begin
      cur = {bus_if.out_last, bus_if.pixel_out0, bus_if.pixel_out1, bus_if.pixel_out2};
      if (bus_if.out_valid) begin
        if (held_v && cur !== held) n_unstable++;
        held   = cur;
        held_v = !bus_if.out_ready;
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        if (bus_if.out_ready) got_q.push_back(cur);
      end else begin
        held_v = 1'b0;
      end
      if (bus_if.frame_done) begin n_fd++; fd_cyc = cyc; end
      if (bus_if.sof_err) begin n_se++; se_cyc = cyc; end
      if (bus_if.in_valid && bus_if.in_ready) acc_cnt++;
      if (!bus_if.in_ready && blk_at < 0) blk_at = acc_cnt;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_px(input logic [4:0] px, input bit sof, output int acc_c);
    bit done = 1'b0;
    acc_c = -1;
    bus_if.in_valid = 1'b1;
    bus_if.in_sof   = sof;
    bus_if.in_pixel = px;
    for (int t = 0; t < 200 && !done; t++) begin
      acc_c = cyc;
      if (bus_if.in_ready) done = 1'b1;
      step();
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_sof   = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL drive_timeout px=%0d in_ready stuck at %b want 1", px, bus_if.in_ready);
    end
  endtask

  task automatic send_frame(input int n, input bit with_sof,
                            output int c0, output int c2, output int cl);
    int c;
    c0 = -1; c2 = -1; cl = -1;
    for (int i = 0; i < n; i++) begin
      drive_px(5'(i % 32), with_sof && (i == 0), c);
      if (i == 0) c0 = c;
      if (i == 2) c2 = c;
      if (i == n - 1) cl = c;
    end
  endtask

  task automatic push_exp(input int ngroups, input bit full_frame);
    logic [4:0] p0, p1, p2;
    for (int g = 0; g < ngroups; g++) begin
      p0 = 5'((3 * g) % 32);
      p1 = (3 * g + 1 < 400) ? 5'((3 * g + 1) % 32) : 5'd0;
      p2 = (3 * g + 2 < 400) ? 5'((3 * g + 2) % 32) : 5'd0;
      exp_q.push_back({full_frame && (g == 133), p0, p1, p2});
    end
  endtask

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.in_sof = 1'b0; bus_if.in_pixel = '0; bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus_if.in_ready);
    else n_pass++;
    n_checks++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus_if.out_valid);
    else n_pass++;
    n_checks++;
    if ({bus_if.out_last, bus_if.pixel_out0, bus_if.pixel_out1, bus_if.pixel_out2} !== 16'h0)
      $display("FAIL reset_data got %b%h%h%h want 0", bus_if.out_last, bus_if.pixel_out0,
               bus_if.pixel_out1, bus_if.pixel_out2);
    else n_pass++;
    n_checks++;
    if ({bus_if.frame_done, bus_if.sof_err} !== 2'b00)
      $display("FAIL reset_pulses got %b%b want 00", bus_if.frame_done, bus_if.sof_err);
    else n_pass++;
  endtask

  task automatic test_frame();
    int c0, c2, cl, d;
    reset_stats();
    send_frame(400, 1'b1, c0, c2, cl);
    idle(10);
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (got_q.size() != 134) $display("FAIL frame_count got %0d want 134", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL frame_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 16'h0022)
      $display("FAIL frame_first got %h want 0022", (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== {1'b1, 5'd15, 5'd0, 5'd0})
      $display("FAIL frame_last got %h want %h",
               (got_q.size() > 0) ? got_q[got_q.size()-1] : 16'hxxxx, {1'b1, 5'd15, 10'd0});
    else n_pass++;
    n_checks++;
    if (first_ov_cyc != c2 + 1) $display("FAIL frame_latency got %0d want %0d", first_ov_cyc, c2 + 1);
    else n_pass++;
    n_checks++;
    if (fd_cyc != cl + 1) $display("FAIL frame_done_cycle got %0d want %0d", fd_cyc, cl + 1);
    else n_pass++;
    n_checks++;
    if (n_fd != 1 || n_se != 0) $display("FAIL frame_pulses got fd=%0d se=%0d want 1 0", n_fd, n_se);
    else n_pass++;
  endtask

  task automatic test_stall();
    int c0, c2, cl, d;
    reset_stats();
    stall_at  = 5;
    stall_rem = 10;
    send_frame(400, 1'b1, c0, c2, cl);
    idle(10);
    stall_at = -1;
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (stall_rem != 0) $display("FAIL stall_applied got %0d left want 0", stall_rem);
    else n_pass++;
    n_checks++;
    if (blk_at != 21) $display("FAIL stall_in_ready_drop got %0d px want 21", blk_at);
    else n_pass++;
    n_checks++;
    if (n_unstable != 0) $display("FAIL stall_stable got %0d changes want 0", n_unstable);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 134) $display("FAIL stall_count got %0d want 134", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL stall_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
  endtask

  task automatic test_idle_drop();
    int c, c0, c2, cl, d;
    reset_stats();
    drive_px(5'd7, 1'b0, c);
    drive_px(5'd8, 1'b0, c);
    send_frame(400, 1'b1, c0, c2, cl);
    idle(10);
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (acc_cnt != 402) $display("FAIL idle_consumed got %0d want 402", acc_cnt);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 134) $display("FAIL idle_count got %0d want 134", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL idle_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
    n_checks++;
    if (n_fd != 1) $display("FAIL idle_frame_done got %0d want 1", n_fd);
    else n_pass++;
  endtask

  task automatic test_sof_restart();
    int c0, c2, cl, r0, r2, rl, d;
    reset_stats();
    send_frame(200, 1'b1, c0, c2, cl);
    send_frame(400, 1'b1, r0, r2, rl);
    idle(10);
    push_exp(66, 1'b0);
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (n_se != 1) $display("FAIL restart_sof_err_count got %0d want 1", n_se);
    else n_pass++;
    n_checks++;
    if (se_cyc != r0) $display("FAIL restart_sof_err_cycle got %0d want %0d", se_cyc, r0);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 200) $display("FAIL restart_count got %0d want 200", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL restart_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
    n_checks++;
    if (n_fd != 1) $display("FAIL restart_frame_done got %0d want 1", n_fd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a0, a2, al, b0, b2, bl, d;
    reset_stats();
    send_frame(400, 1'b1, a0, a2, al);
    send_frame(400, 1'b1, b0, b2, bl);
    idle(10);
    push_exp(134, 1'b1);
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (b0 != al + 1) $display("FAIL b2b_gap got %0d want %0d", b0, al + 1);
    else n_pass++;
    n_checks++;
    if (n_fd != 2) $display("FAIL b2b_frame_done got %0d want 2", n_fd);
    else n_pass++;
    n_checks++;
    if (fd_cyc != bl + 1) $display("FAIL b2b_done_cycle got %0d want %0d", fd_cyc, bl + 1);
    else n_pass++;
    n_checks++;
    if (n_se != 0) $display("FAIL b2b_sof_err got %0d want 0", n_se);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 268) $display("FAIL b2b_count got %0d want 268", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL b2b_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c, c0, c2, cl, d;
    reset_stats();
    send_frame(99, 1'b1, c0, c2, cl);
    force_stall = 1'b1;
    drive_px(5'(99 % 32), 1'b0, c);
    drive_px(5'(100 % 32), 1'b0, c);
    n_checks++;
    if (bus_if.out_valid !== 1'b1) $display("FAIL mid_pre_out_valid got %b want 1", bus_if.out_valid);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    force_stall = 1'b0;
    n_checks++;
    if (bus_if.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", bus_if.out_valid);
    else n_pass++;
    n_checks++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", bus_if.in_ready);
    else n_pass++;
    n_checks++;
    if ({bus_if.out_last, bus_if.pixel_out0, bus_if.pixel_out1, bus_if.pixel_out2} !== 16'h0)
      $display("FAIL mid_data got %b%h%h%h want 0", bus_if.out_last, bus_if.pixel_out0,
               bus_if.pixel_out1, bus_if.pixel_out2);
    else n_pass++;
    reset_stats();
    idle(5);
    drive_px(5'd9, 1'b0, c);
    send_frame(400, 1'b1, c0, c2, cl);
    idle(10);
    push_exp(134, 1'b1);
    d = first_diff();
    n_checks++;
    if (got_q.size() != 134) $display("FAIL mid_after_count got %0d want 134", got_q.size());
    else n_pass++;
    n_checks++;
    if (d >= 0) $display("FAIL mid_after_data idx %0d got %h want %h", d, got_q[d], exp_q[d]);
    else n_pass++;
    n_checks++;
    if (n_fd != 1 || n_se != 0) $display("FAIL mid_after_pulses got fd=%0d se=%0d want 1 0", n_fd, n_se);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_idle_drop();
    test_sof_restart();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
